data_mem_responder: RTL
=======================

// Module: data_mem_responder
// PURPOSE
//  Responder end of the CPU data-memory port; memory_control is the initiator.
//  Accepts one LDR/STR request per transaction on Enable/RW/Address/DataIn.
//  Performs the access after a programmable number of wait states.
//  Answers with a one-cycle Ready pulse, plus read data on Out for loads.
//  Replaces the untimed testbench RAM with a clocked, handshaked memory for the assembled CPU.
// PARAMETERS
//  ADDR_W       16   request address width, matches the Address_out bus
//  DATA_W       32   data word width
//  DEPTH        256  number of words implemented; addresses >= DEPTH are out of range
//  WAIT_CYCLES  1    wait states between accept and response (0..15)
// PORTS
//  Clk      in   1       single clock, rising edge
//  Reset    in   1       synchronous, active-high
//  Enable   in   1       request valid, sampled only in IDLE
//  RW       in   1       1 = read (LDR), 0 = write (STR)
//  Address  in   ADDR_W  word address
//  DataIn   in   DATA_W  store data
//  Out      out  DATA_W  load data; holds last read value
//  Ready    out  1       one-cycle response strobe
//  Busy     out  1       high from accept until end of response cycle
//  Err      out  1       response carried an out-of-range address; valid with Ready
// BEHAVIOUR
//  Reset (sync, active-high): state=IDLE, Out=0, Ready=0, Busy=0, Err=0, wait counter=0.
//   Array contents are NOT reset.
//  States: IDLE -> WAIT -> RESP -> IDLE.
//  IDLE: at an edge with Enable=1, latch RW, Address and DataIn; cnt<=WAIT_CYCLES;
//   Busy<=1; go to WAIT.
//  WAIT: cnt!=0 -> cnt<=cnt-1. cnt==0 -> do the access; Ready<=1; go to RESP.
//   Read: Out<=mem[addr]. Write: mem[addr]<=data.
//  RESP: Ready<=0, Busy<=0, Err<=0; go to IDLE.
//  Latency: request accepted at edge t0 -> Ready high for exactly one cycle after edge t0+WAIT_CYCLES+1.
//  Throughput: one transaction per WAIT_CYCLES+3 cycles at most.
//  Inputs are captured at accept. Input changes after the accept edge have no effect.
//  Enable while Busy=1 or in RESP: ignored, not queued. The requester re-asserts in IDLE.
//  Out-of-range address (Address >= DEPTH):
//   read: Out<=0. Write: dropped, array unchanged. Err=1 for the Ready cycle.
//  Write response: Out keeps its previous value.
//  Reset asserted in WAIT: no write is committed; outputs return to reset values next edge.
//  Reset asserted in RESP: the access already completed; Ready drops at that edge.
//  Reset and Enable at the same edge: Reset wins; the request is lost.
//  WAIT_CYCLES=0: access occurs at edge t0+1 (WAIT lasts one cycle).
//  Counter width is 4 bits; WAIT_CYCLES > 15 is illegal, with an elaboration check.
// CONFIGURATION
//  Macro DMEM_STATS_EN:
//   defined: adds output ports rd_count[15:0] and wr_count[15:0].
//    Each increments on the Ready cycle of an in-range read or write.
//    Each saturates at 16'hFFFF and clears on Reset.
//   undefined: the ports and counters do not exist; all other behaviour is identical.
// STRUCTURE
//  Shared package cpu_mem_pkg:
//   RW_READ=1'b1, RW_WRITE=1'b0.
//   State encodings ST_IDLE=2'd0, ST_WAIT=2'd1, ST_RESP=2'd2.
//  Sub-module dmem_array: single-port synchronous word array.
//   Ports: we, addr, wdata, rdata; read-during-write is not used.
//  This block holds the FSM, wait counter, request latches, range check and optional stats.
// TESTING
//  1. Reset, then check outputs.
//   -> Out=0, Ready=0, Busy=0, Err=0 on the first edge after Reset.
//  2. WAIT_CYCLES=1: write 32'hAAA5 to addr 5, then read addr 5.
//   -> Ready 3 cycles after each accept; Out=32'hAAA5; Err=0.
//  3. Pulse Enable again while Busy=1 (RW=0, addr 6, data 32'h1234).
//   -> ignored; a later read of addr 6 returns the prior contents.
//  4. Read addr 300 with DEPTH=256.
//   -> Out=0, Err=1 for one cycle.
//   Write 32'hDEAD to addr 300 -> array unchanged.
//  5. Write addr 7, then assert Reset in WAIT.
//   -> no Ready; a later read of addr 7 returns the old value; Busy=0 after reset.
//  6. WAIT_CYCLES=0, DMEM_STATS_EN defined: 3 reads and 2 writes back-to-back.
//   -> Ready 2 cycles after each accept; rd_count=3, wr_count=2.

Source files
------------

// File: rtl/cpu_mem_pkg.sv
// ---------------------------------------------------------------------------
// cpu_mem_pkg
// Shared definitions for the CPU data-memory port: read/write encoding of the
// RW line, the responder FSM state encoding, wait-counter limits, and a
// saturating increment helper used by the optional statistics counters.
// ---------------------------------------------------------------------------
package cpu_mem_pkg;

    localparam logic RW_READ  = 1'b1;
    localparam logic RW_WRITE = 1'b0;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_WAIT = 2'd1,
        ST_RESP = 2'd2
    } state_e;

    localparam int CNT_W    = 4;
    localparam int MAX_WAIT = 15;

    // Counters stick at all-ones instead of wrapping back to zero.
    function automatic logic [15:0] satInc16(input logic [15:0] value);
        return (value == 16'hFFFF) ? value : value + 16'd1;
    endfunction

endpackage

// File: rtl/dmem_array.sv
// ---------------------------------------------------------------------------
// dmem_array
// Single-port synchronous word array. Writes commit on the rising edge when
// we is high; rdata is registered and always shows the word addressed at the
// previous edge. Contents are never reset.
// Ports:
//   Clk    in   1       clock, rising edge
//   we     in   1       write enable
//   addr   in   IDX_W   word index
//   wdata  in   DATA_W  write data
//   rdata  out  DATA_W  registered read data
// ---------------------------------------------------------------------------
module dmem_array #(
    parameter int DATA_W = 32,
    parameter int DEPTH  = 256,
    parameter int IDX_W  = 8
) (
    input  logic              Clk,
    input  logic              we,
    input  logic [IDX_W-1:0]  addr,
    input  logic [DATA_W-1:0] wdata,
    output logic [DATA_W-1:0] rdata
);

    logic [DATA_W-1:0] mem [DEPTH];

    always_ff @(posedge Clk) begin
        if (we) begin
            mem[addr] <= wdata;
        end
        rdata <= mem[addr];
    end

endmodule

// File: rtl/data_mem_responder.sv
// ---------------------------------------------------------------------------
// data_mem_responder
// Responder end of the CPU data-memory port. Accepts one LDR/STR request in
// IDLE, waits WAIT_CYCLES wait states, performs the access and answers with
// a one-cycle Ready pulse (plus read data on Out for loads). Addresses at or
// above DEPTH are answered with Err=1; reads return 0, writes are dropped.
// Optional feature macro: DMEM_STATS_EN adds rd_count/wr_count outputs.
// Ports:
//   Clk      in   1       clock, rising edge
//   Reset    in   1       synchronous, active-high
//   Enable   in   1       request valid, sampled only in IDLE
//   RW       in   1       1 = read, 0 = write
//   Address  in   ADDR_W  word address
//   DataIn   in   DATA_W  store data
//   Out      out  DATA_W  load data, holds last read value
//   Ready    out  1       one-cycle response strobe
//   Busy     out  1       high from accept until end of response cycle
//   Err      out  1       out-of-range response, valid with Ready
//   rd_count out  16      (DMEM_STATS_EN) in-range reads, saturating
//   wr_count out  16      (DMEM_STATS_EN) in-range writes, saturating
// ---------------------------------------------------------------------------
module data_mem_responder
    import cpu_mem_pkg::*;
#(
    parameter int ADDR_W      = 16,
    parameter int DATA_W      = 32,
    parameter int DEPTH       = 256,
    parameter int WAIT_CYCLES = 1
) (
    input  logic              Clk,
    input  logic              Reset,
    input  logic              Enable,
    input  logic              RW,
    input  logic [ADDR_W-1:0] Address,
    input  logic [DATA_W-1:0] DataIn,
    output logic [DATA_W-1:0] Out,
    output logic              Ready,
    output logic              Busy,
    output logic              Err
`ifdef DMEM_STATS_EN
    ,
    output logic [15:0]       rd_count,
    output logic [15:0]       wr_count
`endif
);

    localparam int IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [ADDR_W:0] DEPTH_L = (ADDR_W+1)'(DEPTH);
    localparam logic [CNT_W-1:0] WAIT_LOAD = CNT_W'(WAIT_CYCLES);

    generate
        if (WAIT_CYCLES < 0 || WAIT_CYCLES > MAX_WAIT) begin : gWaitCheck
            $error("data_mem_responder: WAIT_CYCLES must be in 0..15");
        end
    endgenerate

    state_e            state_q, state_d;
    logic [CNT_W-1:0]  waitCnt_q, waitCnt_d;
    logic              reqRw_q, reqRw_d;
    logic [ADDR_W-1:0] reqAddr_q, reqAddr_d;
    logic [DATA_W-1:0] reqData_q, reqData_d;
    logic [DATA_W-1:0] out_q, out_d;
    logic              ready_q, ready_d;
    logic              busy_q, busy_d;
    logic              err_q, err_d;
`ifdef DMEM_STATS_EN
    logic [15:0]       rdCount_q, rdCount_d;
    logic [15:0]       wrCount_q, wrCount_d;
`endif

    logic              inRange;
    logic              memWe;
    logic              arrWe;
    logic [IDX_W-1:0]  arrAddr;
    logic [DATA_W-1:0] arrRdata;

    assign inRange = ({1'b0, reqAddr_q} < DEPTH_L);

    // In IDLE the array is pointed at the live Address so that, even with
    // zero wait states, the registered read data is ready on the access edge.
    assign arrAddr = (state_q == ST_IDLE) ? Address[IDX_W-1:0] : reqAddr_q[IDX_W-1:0];

    // A reset landing on the access edge must not commit the write.
    assign arrWe = memWe & ~Reset;

    dmem_array #(
        .DATA_W (DATA_W),
        .DEPTH  (DEPTH),
        .IDX_W  (IDX_W)
    ) u_array (
        .Clk   (Clk),
        .we    (arrWe),
        .addr  (arrAddr),
        .wdata (reqData_q),
        .rdata (arrRdata)
    );

    always_comb begin
        state_d   = state_q;
        waitCnt_d = waitCnt_q;
        reqRw_d   = reqRw_q;
        reqAddr_d = reqAddr_q;
        reqData_d = reqData_q;
        out_d     = out_q;
        ready_d   = ready_q;
        busy_d    = busy_q;
        err_d     = err_q;
        memWe     = 1'b0;
`ifdef DMEM_STATS_EN
        rdCount_d = rdCount_q;
        wrCount_d = wrCount_q;
`endif
        unique case (state_q)
            ST_IDLE: begin
                if (Enable) begin
                    reqRw_d   = RW;
                    reqAddr_d = Address;
                    reqData_d = DataIn;
                    waitCnt_d = WAIT_LOAD;
                    busy_d    = 1'b1;
                    state_d   = ST_WAIT;
                end
            end
            ST_WAIT: begin
                if (waitCnt_q != '0) begin
                    waitCnt_d = waitCnt_q - 1'b1;
                end else begin
                    ready_d = 1'b1;
                    err_d   = ~inRange;
                    state_d = ST_RESP;
                    unique case (reqRw_q)
                        RW_READ: begin
                            out_d = inRange ? arrRdata : '0;
`ifdef DMEM_STATS_EN
                            if (inRange) rdCount_d = satInc16(rdCount_q);
`endif
                        end
                        RW_WRITE: begin
                            memWe = inRange;
`ifdef DMEM_STATS_EN
                            if (inRange) wrCount_d = satInc16(wrCount_q);
`endif
                        end
                        default: ;
                    endcase
                end
            end
            ST_RESP: begin
                ready_d = 1'b0;
                busy_d  = 1'b0;
                err_d   = 1'b0;
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge Clk) begin
        if (Reset) begin
            state_q   <= ST_IDLE;
            waitCnt_q <= '0;
            reqRw_q   <= RW_READ;
            reqAddr_q <= '0;
            reqData_q <= '0;
            out_q     <= '0;
            ready_q   <= 1'b0;
            busy_q    <= 1'b0;
            err_q     <= 1'b0;
`ifdef DMEM_STATS_EN
            rdCount_q <= '0;
            wrCount_q <= '0;
`endif
        end else begin
            state_q   <= state_d;
            waitCnt_q <= waitCnt_d;
            reqRw_q   <= reqRw_d;
            reqAddr_q <= reqAddr_d;
            reqData_q <= reqData_d;
            out_q     <= out_d;
            ready_q   <= ready_d;
            busy_q    <= busy_d;
            err_q     <= err_d;
`ifdef DMEM_STATS_EN
            rdCount_q <= rdCount_d;
            wrCount_q <= wrCount_d;
`endif
        end
    end

    assign Out   = out_q;
    assign Ready = ready_q;
    assign Busy  = busy_q;
    assign Err   = err_q;
`ifdef DMEM_STATS_EN
    assign rd_count = rdCount_q;
    assign wr_count = wrCount_q;
`endif

endmodule
